// File: rtl/gecko_shift_sequencer_pkg.sv
// Shared types for the gecko multi-cycle shift sequencer: operand and amount
// aliases, the RV32I shift type encoding, sequencer states, the latched
// request record and a helper that finds the lowest set bit of an amount.
package gecko_shift_sequencer_pkg;

   typedef logic [31:0] rv32_reg_value_t;
   typedef logic [4:0]  gecko_shift_amount_t;

   typedef enum logic [1:0] {
      GECKO_SHIFT_LL    = 2'd0,
      GECKO_SHIFT_RL    = 2'd1,
      GECKO_SHIFT_RA    = 2'd2,
      GECKO_SHIFT_UNDEF = 2'd3
   } gecko_shift_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } gecko_shift_seq_state_t;

   typedef struct packed {
      rv32_reg_value_t     value;
      gecko_shift_amount_t amount;
      gecko_shift_type_t   shift_type;
   } gecko_shift_request_t;

   localparam int unsigned STRIDE_INDEX_W = 3;

   // Index of the lowest set bit; zero when no bit is set (callers gate on |bits).
   function automatic logic [STRIDE_INDEX_W-1:0] lowest_set_index(input gecko_shift_amount_t bits);
      logic [STRIDE_INDEX_W-1:0] idx;
      idx = '0;
      for (int i = 4; i >= 0; i--) begin
         if (bits[i]) begin
            idx = STRIDE_INDEX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/gecko_shift_sequencer_stage.sv
// Single-stride shift step: shifts the operand by 2^stride_index in the
// requested direction. Arithmetic right shifts fill with the captured sign bit.
module gecko_shift_stage
   import gecko_shift_sequencer_pkg::*;
(
   input  rv32_reg_value_t               in_value,
   input  logic [STRIDE_INDEX_W-1:0]     stride_index,
   input  gecko_shift_type_t             shift_type,
   input  logic                          fill_bit,
   output rv32_reg_value_t               out_value
);

   logic [4:0]  distance;
   logic [32:0] extended;

   // One power-of-two shift; the undefined type behaves as a left shift.
   always_comb begin
      distance  = 5'd1 << stride_index;
      extended  = {fill_bit, in_value};
      out_value = in_value << distance;
      case (shift_type)
         GECKO_SHIFT_RL: out_value = in_value >> distance;
         GECKO_SHIFT_RA: out_value = 32'($signed(extended) >>> distance);
         default:        out_value = in_value << distance;
      endcase
   end

endmodule

// File: rtl/gecko_shift_sequencer.sv
// Multi-cycle shift controller: accepts a shift request, applies it as a
// sequence of power-of-two stride steps (STEPS_PER_CYCLE per cycle, 1 or 2)
// and presents the result on a valid/ready handshake.
module gecko_shift_sequencer
   import gecko_shift_sequencer_pkg::*;
#(
   parameter int unsigned STEPS_PER_CYCLE = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  rv32_reg_value_t     cmd_value,
   input  gecko_shift_amount_t cmd_amount,
   input  gecko_shift_type_t   cmd_type,
   output logic                result_valid,
   input  logic                result_ready,
   output rv32_reg_value_t     result_value,
   output logic                busy
);

   gecko_shift_seq_state_t state_q, state_d;
   gecko_shift_request_t   req_q, req_d;
   logic                   fill_q, fill_d;
   rv32_reg_value_t        result_q, result_d;

   logic [STEPS_PER_CYCLE-1:0]                     step_valid;
   logic [STEPS_PER_CYCLE-1:0][STRIDE_INDEX_W-1:0] step_index;
   gecko_shift_amount_t                            remaining_after;
   rv32_reg_value_t                                shifted_value;
   logic                                           accept;

   // Pick the lowest set bits of the remaining amount for this cycle's steps.
   always_comb begin : step_select
      gecko_shift_amount_t rem;
      rem        = req_q.amount;
      step_valid = '0;
      step_index = '0;
      for (int k = 0; k < int'(STEPS_PER_CYCLE); k++) begin
         step_valid[k] = |rem;
         step_index[k] = lowest_set_index(rem);
         rem           = rem & (rem - 5'd1);
      end
      remaining_after = rem;
   end

   for (genvar k = 0; k < int'(STEPS_PER_CYCLE); k++) begin : g_step
      rv32_reg_value_t stage_in;
      rv32_reg_value_t stage_out;
      rv32_reg_value_t stage_res;

      if (k == 0) begin : g_first
         assign stage_in = req_q.value;
      end else begin : g_next
         assign stage_in = g_step[k-1].stage_res;
      end

      gecko_shift_stage u_stage (
         .in_value     (stage_in),
         .stride_index (step_index[k]),
         .shift_type   (req_q.shift_type),
         .fill_bit     (fill_q),
         .out_value    (stage_out)
      );

      assign stage_res = step_valid[k] ? stage_out : stage_in;
   end

   assign shifted_value = g_step[STEPS_PER_CYCLE-1].stage_res;

   assign cmd_ready    = (state_q == IDLE) && !flush;
   assign accept       = cmd_valid && cmd_ready;
   assign result_valid = (state_q == DONE);
   assign result_value = result_q;
   assign busy         = (state_q != IDLE);

   // Next-state logic: accept in IDLE, step in SHIFT, hand off in DONE; flush wins.
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      fill_d   = fill_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_d.value      = cmd_value;
               req_d.amount     = cmd_amount;
               req_d.shift_type = cmd_type;
               fill_d           = cmd_value[31];
               if (cmd_amount == '0) begin
                  result_d = cmd_value;
                  state_d  = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            req_d.value  = shifted_value;
            req_d.amount = remaining_after;
            if (remaining_after == '0) begin
               result_d = shifted_value;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d      = IDLE;
         req_d.amount = '0;
         result_d     = result_q;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         fill_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         fill_q   <= fill_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_gecko_shift_sequencer.sv
// Directed bench for gecko_shift_sequencer: one instance per legal
// STEPS_PER_CYCLE value, both driven by the same command stream.
module tb_gecko_shift_sequencer;
   import gecko_shift_sequencer_pkg::*;

   typedef struct {
      gecko_shift_type_t shift_type;
      logic [31:0]       value;
      logic [4:0]        amount;
      logic [31:0]       expected;
      int                lat1;
      int                lat2;
   } vector_t;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              cmd_valid;
   logic [31:0]       cmd_value;
   logic [4:0]        cmd_amount;
   gecko_shift_type_t cmd_type;
   logic              result_ready;

   logic        out1_cmd_ready, out1_result_valid, out1_busy;
   logic [31:0] out1_result_value;
   logic        out2_cmd_ready, out2_result_valid, out2_busy;
   logic [31:0] out2_result_value;

   int checks = 0;
   int errors = 0;

   vector_t vectors [12];

   gecko_shift_sequencer #(.STEPS_PER_CYCLE(1)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (out1_cmd_ready),
      .cmd_value    (cmd_value),
      .cmd_amount   (cmd_amount),
      .cmd_type     (cmd_type),
      .result_valid (out1_result_valid),
      .result_ready (result_ready),
      .result_value (out1_result_value),
      .busy         (out1_busy)
   );

   gecko_shift_sequencer #(.STEPS_PER_CYCLE(2)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (out2_cmd_ready),
      .cmd_value    (cmd_value),
      .cmd_amount   (cmd_amount),
      .cmd_type     (cmd_type),
      .result_valid (out2_result_valid),
      .result_ready (result_ready),
      .result_value (out2_result_value),
      .busy         (out2_busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a wait is never satisfied.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
      end
   endtask

   task automatic checkIdle(input string name);
      checkFlag({name, " cmd_ready1"}, out1_cmd_ready, 1'b1);
      checkFlag({name, " busy1"}, out1_busy, 1'b0);
      checkFlag({name, " valid1"}, out1_result_valid, 1'b0);
      checkFlag({name, " cmd_ready2"}, out2_cmd_ready, 1'b1);
      checkFlag({name, " busy2"}, out2_busy, 1'b0);
      checkFlag({name, " valid2"}, out2_result_valid, 1'b0);
   endtask

   // Issue one request from a negedge and watch both instances for their result.
   task automatic applyStimulus(input gecko_shift_type_t t, input logic [31:0] v, input logic [4:0] a,
                                output int lat1, output logic [31:0] res1,
                                output int lat2, output logic [31:0] res2);
      cmd_valid  = 1'b1;
      cmd_value  = v;
      cmd_amount = a;
      cmd_type   = t;
      checkFlag("accept cmd_ready1", out1_cmd_ready, 1'b1);
      checkFlag("accept cmd_ready2", out2_cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat1 = 0;
      lat2 = 0;
      res1 = '0;
      res2 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (out1_result_valid && lat1 == 0) begin
            lat1 = c;
            res1 = out1_result_value;
         end
         if (out2_result_valid && lat2 == 0) begin
            lat2 = c;
            res2 = out2_result_value;
         end
      end
   endtask

   // Directed test sequence.
   initial begin
      int          lat1, lat2, seen, vcount;
      logic [31:0] res1, res2;

      vectors[0]  = '{GECKO_SHIFT_RL,    32'h8000_0001, 5'd5,  32'h0400_0000, 3, 2};
      vectors[1]  = '{GECKO_SHIFT_RA,    32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6, 4};
      vectors[2]  = '{GECKO_SHIFT_LL,    32'h0000_0001, 5'd0,  32'h0000_0001, 1, 1};
      vectors[3]  = '{GECKO_SHIFT_LL,    32'h0000_0003, 5'd31, 32'h8000_0000, 6, 4};
      vectors[4]  = '{GECKO_SHIFT_RA,    32'h7000_0000, 5'd4,  32'h0700_0000, 2, 2};
      vectors[5]  = '{GECKO_SHIFT_UNDEF, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 2, 2};
      vectors[6]  = '{GECKO_SHIFT_RA,    32'hF000_0000, 5'd6,  32'hFFC0_0000, 3, 2};
      vectors[7]  = '{GECKO_SHIFT_RL,    32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 6, 4};
      vectors[8]  = '{GECKO_SHIFT_LL,    32'h1234_5678, 5'd12, 32'h4567_8000, 3, 2};
      vectors[9]  = '{GECKO_SHIFT_RA,    32'h8000_0000, 5'd1,  32'hC000_0000, 2, 2};
      vectors[10] = '{GECKO_SHIFT_RL,    32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 2, 2};
      vectors[11] = '{GECKO_SHIFT_LL,    32'hDEAD_BEEF, 5'd7,  32'h56DF_7780, 4, 3};

      rst          = 1'b1;
      flush        = 1'b0;
      cmd_valid    = 1'b0;
      cmd_value    = '0;
      cmd_amount   = '0;
      cmd_type     = GECKO_SHIFT_LL;
      result_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkIdle("reset");
      checkOutput("reset value1", out1_result_value, 32'h0);
      checkOutput("reset value2", out2_result_value, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] vector table");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vectors[i].shift_type, vectors[i].value, vectors[i].amount, lat1, res1, lat2, res2);
         checkOutput($sformatf("vec%0d result1", i), res1, vectors[i].expected);
         checkOutput($sformatf("vec%0d latency1", i), lat1, vectors[i].lat1);
         checkOutput($sformatf("vec%0d result2", i), res2, vectors[i].expected);
         checkOutput($sformatf("vec%0d latency2", i), lat2, vectors[i].lat2);
      end

      $display("[TB] backpressure");
      result_ready = 1'b0;
      cmd_valid    = 1'b1;
      cmd_value    = 32'h0000_0001;
      cmd_amount   = 5'd2;
      cmd_type     = GECKO_SHIFT_LL;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      seen = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (out1_result_valid && out2_result_valid) begin
            seen = c;
            break;
         end
      end
      checkOutput("bp rise cycle", seen, 2);
      cmd_valid  = 1'b1;
      cmd_value  = 32'hAAAA_5555;
      cmd_amount = 5'd0;
      for (int h = 0; h < 3; h++) begin
         checkFlag($sformatf("bp hold%0d valid1", h), out1_result_valid, 1'b1);
         checkOutput($sformatf("bp hold%0d value1", h), out1_result_value, 32'h0000_0004);
         checkFlag($sformatf("bp hold%0d cmd_ready1", h), out1_cmd_ready, 1'b0);
         checkFlag($sformatf("bp hold%0d busy1", h), out1_busy, 1'b1);
         checkOutput($sformatf("bp hold%0d value2", h), out2_result_value, 32'h0000_0004);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      checkFlag("bp accept valid1", out1_result_valid, 1'b1);
      checkOutput("bp accept value1", out1_result_value, 32'h0000_0004);
      result_ready = 1'b1;
      @(negedge clk);
      checkIdle("bp after");

      $display("[TB] flush");
      cmd_valid  = 1'b1;
      cmd_value  = 32'h8000_0000;
      cmd_amount = 5'd31;
      cmd_type   = GECKO_SHIFT_RA;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkFlag("flush pre busy1", out1_busy, 1'b1);
      checkFlag("flush pre busy2", out2_busy, 1'b1);
      flush      = 1'b1;
      cmd_valid  = 1'b1;
      cmd_value  = 32'h0000_0001;
      cmd_amount = 5'd0;
      cmd_type   = GECKO_SHIFT_LL;
      #1;
      checkFlag("flush cmd_ready1", out1_cmd_ready, 1'b0);
      checkFlag("flush cmd_ready2", out2_cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      checkIdle("flush after");
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         if (out1_result_valid || out2_result_valid) vcount++;
         @(negedge clk);
      end
      checkOutput("flush valid count", vcount, 0);
      applyStimulus(GECKO_SHIFT_RL, 32'hF000_0000, 5'd4, lat1, res1, lat2, res2);
      checkOutput("post flush result1", res1, 32'h0F00_0000);
      checkOutput("post flush latency1", lat1, 2);
      checkOutput("post flush result2", res2, 32'h0F00_0000);
      checkOutput("post flush latency2", lat2, 2);

      $display("[TB] reset mid shift");
      cmd_valid  = 1'b1;
      cmd_value  = 32'h8000_0000;
      cmd_amount = 5'd31;
      cmd_type   = GECKO_SHIFT_RA;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkFlag("rst pre busy1", out1_busy, 1'b1);
      rst = 1'b1;
      #1;
      checkIdle("rst async");
      checkOutput("rst async value1", out1_result_value, 32'h0);
      checkOutput("rst async value2", out2_result_value, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(GECKO_SHIFT_LL, 32'h0000_0001, 5'd31, lat1, res1, lat2, res2);
      checkOutput("post rst result1", res1, 32'h8000_0000);
      checkOutput("post rst latency1", lat1, 6);
      checkOutput("post rst result2", res2, 32'h8000_0000);
      checkOutput("post rst latency2", lat2, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gecko_shift_sequencer.md
# gecko_shift_sequencer

Multi-cycle shift controller for the gecko execute stage. It accepts one RV32I shift request (left logical, right logical, right arithmetic) over a valid/ready handshake. It decomposes the 5-bit shift amount into power-of-two stride steps and drives a single-stride shift stage once per step, so the full 32-bit barrel shifter stays out of the critical path. It returns the shifted value on a second valid/ready handshake. Execute routes shift ops here in place of the combinational ALU shift result.

## Interface
- STEPS_PER_CYCLE, 1: stride steps applied per cycle; legal values 1 or 2.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort any in-flight request and drop its result
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted when both high at clk edge
- cmd_value  in  32  operand (rv32_reg_value_t)
- cmd_amount  in  5  shift amount (gecko_shift_amount_t)
- cmd_type  in  2  gecko_shift_type_t
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_value  out  32  shifted value
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- cmd_ready = (state == IDLE) && !flush. No overlap between requests.
- Accept in IDLE:
  - Latch value, type, and remaining = cmd_amount.
  - Go to DONE if amount == 0; otherwise go to SHIFT.
- SHIFT, each cycle:
  - Select the lowest STEPS_PER_CYCLE set bits of remaining, lowest first.
  - For each selected bit i, apply a shift by 2^i through the stage.
  - Clear the applied bits from remaining.
  - Go to DONE when remaining becomes 0 this cycle.
- Type rules:
  - LL: zero fill from the right.
  - RL: zero fill from the left.
  - RA: fill with bit 31 of the original operand, captured at accept.
  - GECKO_SHIFT_UNDEF: executed as LL.
- Composition: every stride shift is exact mod 32, so the composed result equals the single shift by cmd_amount.
- DONE: result_valid = 1, result_value held stable. When result_ready = 1, go to IDLE.
- flush (synchronous, any state): next state IDLE, result_valid = 0, result discarded. A cmd_valid in the same cycle is not accepted.
- flush has priority over result_ready in DONE.

## Timing
- Reset values: state IDLE, cmd_ready 1 (when flush = 0), result_valid 0, result_value 0, busy 0, remaining 0.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously; no partial result is ever presented.
- Latency (accept at cycle 0):
  - result_valid rises at cycle ceil(popcount(amount)/STEPS_PER_CYCLE) + 1.
  - Amount 0 gives cycle 1.
  - Worst case: 6 cycles at STEPS=1, 4 cycles at STEPS=2.
- Result handshake in the same cycle as result_valid rises is permitted; cmd_ready rises the following cycle.
- Minimum request-to-request spacing: latency + 1 cycles.
- result_value changes only on the SHIFT->DONE or IDLE->DONE transition.
- cmd_* inputs are ignored outside IDLE.

## Structure
- Additions to the gecko package:
  - gecko_shift_seq_state_t enum (IDLE/SHIFT/DONE).
  - gecko_shift_request_t struct (value, amount, type). Reuses the existing gecko_shift_type_t and gecko_shift_amount_t.
- Sub-module gecko_shift_stage: purely combinational, single-stride step.
  - Inputs: value, stride index 0..4, type, fill bit. Output: value.
  - Instantiated STEPS_PER_CYCLE times, chained.
- Sequencer keeps all state; no other sub-modules.

## Test plan
- STEPS=1, RL, value 0x8000_0001, amount 5 -> strides 1 then 4; result_valid at cycle 3; result 0x0400_0000.
- STEPS=1, RA, value 0x8000_0000, amount 31 -> result_valid at cycle 6; result 0xFFFF_FFFF. Then LL, value 0x0000_0001, amount 0 -> result_valid at cycle 1; result 0x0000_0001.
- STEPS=2, LL, value 0x0000_0003, amount 31 -> result_valid at cycle 4; result 0x8000_0000.
- Backpressure: result_ready held low 3 cycles in DONE -> result_valid and result_value stable, cmd_ready 0, busy 1. Result accepted on the 4th cycle; cmd_ready 1 on the next cycle.
- flush in the 2nd SHIFT cycle of an amount-31 request, with cmd_valid also high -> next cycle IDLE, result_valid never asserts, command not accepted that cycle. A following RL request (0xF000_0000 by 4) returns 0x0F00_0000.
- Assert rst mid-SHIFT -> outputs immediately at reset values. After release, a request is accepted in the first cycle and completes correctly.
